dram_resp: RTL

- Memory-side responder for the accelerator's DRAM port.
- Services the read requests (addr_in, dram_en_rd) and write requests (addr_out, dram_en_wr, wdata) issued by the layer controllers.
- Returns read data after a fixed, parameterised latency.
- Also provides a host preload/readback port, used to fill parameters, weights and ifmaps and to dump ofmaps.

---
 rtl/dram_resp.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/dram_resp.sv
`default_nettype none
// ============================================================================
// Module   : dram_resp
// Brief    : DRAM-side responder: pipelined engine read/write port, host
//            preload/readback port, out-of-range flag, optional request
//            counters (enabled by DRAM_RESP_STATS_EN).
// Revision : 1.0  initial release
// ============================================================================
module dram_resp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 18,
    parameter int MEM_DEPTH  = 196608,
    parameter int RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  srstn,
    input  logic                  dram_en_rd,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic [5:0]            param_out,
    input  logic                  dram_en_wr,
    input  logic [ADDR_WIDTH-1:0] addr_out,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  host_wr_en,
    input  logic                  host_rd_en,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic                  host_rvalid,
    output logic                  host_drop,
    output logic                  err_oob,
    input  logic                  clr,
    output logic [31:0]           rd_cnt,
    output logic [31:0]           wr_cnt
);

    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(MEM_DEPTH);
    localparam logic [31:0]         CNT_MAX   = 32'hFFFF_FFFF;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic                  w_rd_ok;
    logic                  w_wr_ok;
    logic                  w_host_ok;
    logic                  w_eng_busy;
    logic                  w_host_req;
    logic                  w_host_acc;
    logic                  w_oob_evt;
    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_mem_waddr;
    logic [DATA_WIDTH-1:0] w_mem_wdata;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic [DATA_WIDTH-1:0] w_host_word;

    logic [RD_LAT-1:0]     r_pipe_vld;
    logic [DATA_WIDTH-1:0] r_pipe_data [RD_LAT];

    assign w_rd_ok    = {1'b0, addr_in}   < DEPTH_EXT;
    assign w_wr_ok    = {1'b0, addr_out}  < DEPTH_EXT;
    assign w_host_ok  = {1'b0, host_addr} < DEPTH_EXT;
    assign w_eng_busy = dram_en_rd | dram_en_wr;
    assign w_host_req = host_wr_en | host_rd_en;
    assign w_host_acc = w_host_req & ~w_eng_busy;
    assign w_oob_evt  = (dram_en_rd & ~w_rd_ok) | (dram_en_wr & ~w_wr_ok)
                      | (w_host_acc & ~w_host_ok);

    // Single physical write port: the host only gets it when the engine is idle.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_waddr = addr_out;
        w_mem_wdata = wdata;
        if (dram_en_wr && w_wr_ok) begin
            w_mem_we = 1'b1;
        end else if (w_host_acc && host_wr_en && w_host_ok) begin
            w_mem_we    = 1'b1;
            w_mem_waddr = host_addr;
            w_mem_wdata = host_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            mem[w_mem_waddr] <= w_mem_wdata;
        end
    end

    // Write-first: a same-cycle write to the read address is forwarded.
    always_comb begin
        w_rd_word = '0;
        if (w_rd_ok) begin
            w_rd_word = (dram_en_wr && (addr_out == addr_in)) ? wdata : mem[addr_in];
        end
    end

    always_comb begin
        w_host_word = '0;
        if (w_host_ok) begin
            w_host_word = host_wr_en ? host_wdata : mem[host_addr];
        end
    end

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            r_pipe_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_pipe_data[i] <= '0;
            end
        end else begin
            r_pipe_vld[0]  <= dram_en_rd;
            r_pipe_data[0] <= w_rd_word;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe_vld[i]  <= r_pipe_vld[i-1];
                r_pipe_data[i] <= r_pipe_data[i-1];
            end
        end
    end

    assign rvalid    = r_pipe_vld[RD_LAT-1];
    assign rdata     = r_pipe_data[RD_LAT-1];
    assign param_out = rdata[5:0];

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            host_rdata  <= '0;
            host_rvalid <= 1'b0;
            host_drop   <= 1'b0;
            err_oob     <= 1'b0;
        end else begin
            host_rvalid <= w_host_acc & host_rd_en;
            host_drop   <= w_host_req & w_eng_busy;
            if (w_host_acc && host_rd_en) begin
                host_rdata <= w_host_word;
            end
            err_oob <= clr ? 1'b0 : (err_oob | w_oob_evt);
        end
    end

`ifdef DRAM_RESP_STATS_EN
    logic [31:0] r_rd_cnt;
    logic [31:0] r_wr_cnt;

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else if (clr) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else begin
            if (dram_en_rd && (r_rd_cnt != CNT_MAX)) r_rd_cnt <= r_rd_cnt + 32'd1;
            if (dram_en_wr && (r_wr_cnt != CNT_MAX)) r_wr_cnt <= r_wr_cnt + 32'd1;
        end
    end

    assign rd_cnt = r_rd_cnt;
    assign wr_cnt = r_wr_cnt;
`else
    assign rd_cnt = '0;
    assign wr_cnt = '0;
`endif

endmodule
`default_nettype wire
